// File: rtl/cntr_pkg.sv
// cntr_pkg: state encoding and shared constants for cntr_nbits_fsm.
package cntr_pkg;
   localparam int STATE_W = 3;
   typedef enum logic [STATE_W-1:0] {
      IDLE = 3'b000,
      LOAD = 3'b001,
      INC  = 3'b010,
      INC2 = 3'b011,
      DEC  = 3'b100,
      DEC2 = 3'b101
   } state_e;
   localparam state_e ILLEGAL_NEXT = IDLE;
endpackage

// File: rtl/cntr_ns_logic.sv
// cntr_ns_logic: next-state decoder, priority load > inc > dec, repeats accelerate.
module cntr_ns_logic
   import cntr_pkg::*;
(
   input  state_e state,
   input  logic   load,
   input  logic   inc,
   input  logic   dec,
   output state_e next_state
);
   always_comb begin
      next_state = ILLEGAL_NEXT;
      if (state inside {IDLE, LOAD, INC, INC2, DEC, DEC2})
         next_state = load ? LOAD
                    : inc  ? ((state == INC || state == INC2) ? INC2 : INC)
                    : dec  ? ((state == DEC || state == DEC2) ? DEC2 : DEC)
                    : IDLE;
   end
endmodule

// File: rtl/cntr_nbits_fsm.sv
// cntr_nbits_fsm: loadable up/down counter with +-2 acceleration, wrap/saturate, tc flags; CNTR_OVF_FLAG_EN adds sticky ovf.
module cntr_nbits_fsm
   import cntr_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             inc,
   input  logic             dec,
   input  logic             load,
   input  logic [WIDTH-1:0] d_in,
   input  logic             wrap,
   output logic [WIDTH-1:0] d_out,
   output logic [2:0]       o_state,
   output logic             tc_max,
   output logic             tc_min
`ifdef CNTR_OVF_FLAG_EN
   ,
   output logic             ovf
`endif
);
   state_e           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH:0]   ext, step, res;
   logic             up, dn, two, oor;

   cntr_ns_logic u_ns (
      .state      (state_q),
      .load       (load),
      .inc        (inc),
      .dec        (dec),
      .next_state (state_d)
   );

   // The extra top bit of res is the carry (up) or borrow (down).
   always_comb begin
      up    = state_d == INC || state_d == INC2;
      dn    = state_d == DEC || state_d == DEC2;
      two   = state_d == INC2 || state_d == DEC2;
      ext   = {1'b0, cnt_q};
      step  = {{(WIDTH-1){1'b0}}, two, ~two};
      res   = up ? ext + step : ext - step;
      oor   = (up | dn) & res[WIDTH];
      cnt_d = state_d == LOAD ? d_in
            : !(up | dn)      ? cnt_q
            : (oor && !wrap)  ? (up ? {WIDTH{1'b1}} : {WIDTH{1'b0}})
            : res[WIDTH-1:0];
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef CNTR_OVF_FLAG_EN
   logic ovf_q, ovf_d;
   always_comb ovf_d = state_d == LOAD ? 1'b0 : ovf_q | oor;
   always_ff @(posedge clk) begin
      if (!reset_n) ovf_q <= 1'b0;
      else ovf_q <= ovf_d;
   end
   assign ovf = ovf_q;
`endif

   assign d_out   = cnt_q;
   assign o_state = state_q;
   assign tc_max  = &cnt_q;
   assign tc_min  = ~|cnt_q;
endmodule

// File: tb/tb_cntr_nbits_fsm.sv
// tb_cntr_nbits_fsm: directed vectors with a queue scoreboard drained by a per-cycle monitor.
module tb_cntr_nbits_fsm;
   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       inc = 1'b0, dec = 1'b0, load = 1'b0, wrap = 1'b0;
   logic [7:0] d_in = 8'h00;
   logic [7:0] d_out;
   logic [2:0] o_state;
   logic       tc_max, tc_min;
`ifdef CNTR_OVF_FLAG_EN
   logic       ovf;
`endif

   typedef struct {
      string      nm;
      logic [7:0] d;
      logic [2:0] s;
      logic       o;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   cntr_nbits_fsm #(.WIDTH(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (inc),
      .dec     (dec),
      .load    (load),
      .d_in    (d_in),
      .wrap    (wrap),
      .d_out   (d_out),
      .o_state (o_state),
      .tc_max  (tc_max),
      .tc_min  (tc_min)
`ifdef CNTR_OVF_FLAG_EN
      ,
      .ovf     (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk(e.nm, "d_out", 32'(d_out), 32'(e.d));
         chk(e.nm, "state", 32'(o_state), 32'(e.s));
         chk(e.nm, "tc_max", 32'(tc_max), 32'(e.d == 8'hFF));
         chk(e.nm, "tc_min", 32'(tc_min), 32'(e.d == 8'h00));
`ifdef CNTR_OVF_FLAG_EN
         chk(e.nm, "ovf", 32'(ovf), 32'(e.o));
`endif
      end
   end

   task automatic cyc(input logic rn, input logic ld, input logic in, input logic de,
                      input logic [7:0] din, input logic wr,
                      input logic [7:0] ed, input logic [2:0] es, input logic eo, input string nm);
      exp_t e;
      @(negedge clk);
      reset_n = rn; load = ld; inc = in; dec = de; d_in = din; wrap = wr;
      e.nm = nm; e.d = ed; e.s = es; e.o = eo;
      exp_q.push_back(e);
   endtask

   initial begin
      // reset held 2 cycles with inc asserted
      cyc(0, 0, 1, 0, 8'h00, 0, 8'h00, 3'b000, 0, "rst0");
      cyc(0, 0, 1, 0, 8'h00, 0, 8'h00, 3'b000, 0, "rst1");
      cyc(1, 0, 0, 0, 8'h00, 0, 8'h00, 3'b000, 0, "idle");
      // load then accelerate up
      cyc(1, 1, 0, 0, 8'h10, 0, 8'h10, 3'b001, 0, "ld10");
      cyc(1, 0, 1, 0, 8'h00, 0, 8'h11, 3'b010, 0, "acc1");
      cyc(1, 0, 1, 0, 8'h00, 0, 8'h13, 3'b011, 0, "acc2");
      cyc(1, 0, 1, 0, 8'h00, 0, 8'h15, 3'b011, 0, "acc3");
      cyc(1, 0, 1, 0, 8'h00, 0, 8'h17, 3'b011, 0, "acc4");
      // wrap at MAX, then saturate at MAX
      cyc(1, 1, 0, 0, 8'hFE, 1, 8'hFE, 3'b001, 0, "w_ldFE");
      cyc(1, 0, 1, 0, 8'h00, 1, 8'hFF, 3'b010, 0, "w_inc1");
      cyc(1, 0, 1, 0, 8'h00, 1, 8'h01, 3'b011, 1, "w_inc2");
      cyc(1, 0, 0, 0, 8'h00, 1, 8'h01, 3'b000, 1, "w_idle");
      cyc(1, 1, 0, 0, 8'hFE, 0, 8'hFE, 3'b001, 0, "s_ldFE");
      cyc(1, 0, 1, 0, 8'h00, 0, 8'hFF, 3'b010, 0, "s_inc1");
      cyc(1, 0, 1, 0, 8'h00, 0, 8'hFF, 3'b011, 1, "s_inc2");
      // downward acceleration, saturate then wrap
      cyc(1, 1, 0, 0, 8'h03, 0, 8'h03, 3'b001, 0, "s_ld03");
      cyc(1, 0, 0, 1, 8'h00, 0, 8'h02, 3'b100, 0, "s_dec1");
      cyc(1, 0, 0, 1, 8'h00, 0, 8'h00, 3'b101, 0, "s_dec2");
      cyc(1, 0, 0, 1, 8'h00, 0, 8'h00, 3'b101, 1, "s_dec3");
      cyc(1, 1, 0, 0, 8'h03, 1, 8'h03, 3'b001, 0, "w_ld03");
      cyc(1, 0, 0, 1, 8'h00, 1, 8'h02, 3'b100, 0, "w_dec1");
      cyc(1, 0, 0, 1, 8'h00, 1, 8'h00, 3'b101, 0, "w_dec2");
      cyc(1, 0, 0, 1, 8'h00, 1, 8'hFE, 3'b101, 1, "w_dec3");
      // priority and acceleration break
      cyc(1, 1, 0, 0, 8'h10, 0, 8'h10, 3'b001, 0, "p_ld10");
      cyc(1, 0, 1, 0, 8'h00, 0, 8'h11, 3'b010, 0, "p_inc1");
      cyc(1, 0, 1, 0, 8'h00, 0, 8'h13, 3'b011, 0, "p_inc2");
      cyc(1, 1, 1, 1, 8'h40, 0, 8'h40, 3'b001, 0, "p_all");
      cyc(1, 0, 0, 1, 8'h00, 0, 8'h3F, 3'b100, 0, "p_dec");
      cyc(1, 0, 1, 0, 8'h00, 0, 8'h40, 3'b010, 0, "p_brk_inc");
      cyc(1, 0, 1, 1, 8'h00, 0, 8'h42, 3'b011, 0, "p_inc_dec");
      cyc(1, 0, 0, 1, 8'h00, 0, 8'h41, 3'b100, 0, "p_brk_dec");
      // overflow flag: set by wrap, sticky through idle, cleared by load
      cyc(1, 1, 0, 0, 8'hFF, 1, 8'hFF, 3'b001, 0, "o_ldFF");
      cyc(1, 0, 1, 0, 8'h00, 1, 8'h00, 3'b010, 1, "o_inc");
      cyc(1, 0, 0, 0, 8'h00, 1, 8'h00, 3'b000, 1, "o_idle1");
      cyc(1, 0, 0, 0, 8'h00, 0, 8'h00, 3'b000, 1, "o_idle2");
      cyc(1, 1, 0, 0, 8'h05, 0, 8'h05, 3'b001, 0, "o_ld05");
      // reset in the middle of acceleration, then restart at INC
      cyc(1, 0, 1, 0, 8'h00, 0, 8'h06, 3'b010, 0, "m_inc1");
      cyc(1, 0, 1, 0, 8'h00, 0, 8'h08, 3'b011, 0, "m_inc2");
      cyc(0, 0, 1, 0, 8'h00, 0, 8'h00, 3'b000, 0, "m_rst");
      cyc(1, 0, 1, 0, 8'h00, 0, 8'h01, 3'b010, 0, "m_inc3");
      cyc(1, 0, 0, 0, 8'h00, 0, 8'h01, 3'b000, 0, "m_idle");
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/cntr_nbits_fsm.md
Name: cntr_nbits_fsm

Overview:
- Parametrised successor to the team's 8-bit loadable up/down counter.
- Width is generic.
- Adds an accelerated step (±2) when inc or dec is held for consecutive cycles.
- Adds a selectable wrap or saturate mode, plus terminal-count flags.
- Built on the shared gate library; used as a general event/address counter in lab datapaths.

Parameters:
- WIDTH, 8, counter and data width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous active-low reset.
- inc  input  1  request count up.
- dec  input  1  request count down.
- load  input  1  load d_in into counter.
- d_in  input  WIDTH  load value.
- wrap  input  1  1 = modulo-2^WIDTH wrap; 0 = saturate at 0 / MAX.
- d_out  output  WIDTH  current count (registered).
- o_state  output  3  current FSM state (registered).
- tc_max  output  1  d_out == 2^WIDTH-1 (combinational from register).
- tc_min  output  1  d_out == 0 (combinational from register).

Behaviour:
- Reset:
  - Sampled on rising clk with reset_n == 0.
  - d_out = 0, o_state = IDLE; tc_min = 1, tc_max = 0 after the edge.
  - Reset overrides all inputs, including mid-acceleration.
- State encoding (3 bits): IDLE=000, LOAD=001, INC=010, INC2=011, DEC=100, DEC2=101. Codes 110 and 111 are illegal and return to IDLE on the next edge with d_out held.
- Input priority: load > inc > dec. Any lower-priority request asserted together with a higher one is ignored.
- Next state:
  - load=1 → LOAD, from any state.
  - else inc=1 → INC2 if current state is INC or INC2, otherwise INC.
  - else dec=1 → DEC2 if current state is DEC or DEC2, otherwise DEC.
  - else → IDLE.
- Counter update, on the same edge that enters the state:
  - LOAD: d_out = d_in.
  - INC: +1.
  - INC2: +2.
  - DEC: −1.
  - DEC2: −2.
  - IDLE: hold.
- Latency: one cycle. Inputs sampled at edge N appear on d_out/o_state after edge N.
- Arithmetic is WIDTH+1 bits internally; the carry/borrow bit decides overflow.
- wrap=1: result taken modulo 2^WIDTH. Examples: MAX+1 → 0, MAX−1+2 → 0, 1−2 → MAX.
- wrap=0:
  - Any result above MAX clamps to MAX; any result below 0 clamps to 0.
  - The FSM still advances to INC2/DEC2 while clamped.
- wrap is sampled every edge and may change mid-run; it applies to that edge's update only.
- A dec arriving in INC/INC2 breaks acceleration: the state goes to DEC (step −1). Symmetric for inc arriving in DEC/DEC2.
- load during INC2/DEC2 ends acceleration. A following inc starts again at INC.

Optional Feature:
- Macro: CNTR_OVF_FLAG_EN.
- Defined:
  - Adds output port ovf (1 bit, registered, reset 0).
  - Set sticky on any edge where the unclamped result leaves 0..MAX, in either wrap mode.
  - Cleared by LOAD or reset. Set and LOAD on the same edge → LOAD wins (ovf=0).
- Undefined: no ovf port, no overflow register; all other behaviour identical.

Decomposition:
- Shared package cntr_pkg holds:
  - the 3-bit state localparams IDLE..DEC2;
  - the state width constant;
  - the illegal-state default.
- One sub-module, cntr_ns_logic: purely combinational next-state decoder (state, load, inc, dec → next_state).
- Top holds the state register, the WIDTH+1 adder/subtractor with wrap/saturate select, and the tc compare.

Test Plan (WIDTH=8):
- Reset: reset_n=0 for 2 cycles, with inc=1 asserted during reset → d_out=0x00, o_state=000, tc_min=1; inc has no effect until reset_n=1.
- Load and acceleration: load d_in=0x10, then inc held 4 cycles → d_out 0x10, 0x11, 0x13, 0x15, 0x17; states 001, 010, 011, 011, 011.
- Wrap at MAX: wrap=1, load 0xFE, inc held 2 cycles → 0xFF (tc_max=1), then 0x01. Same run with wrap=0 → 0xFF, 0xFF.
- Downward acceleration and saturate: wrap=0, load 0x03, dec held 3 cycles → 0x02, 0x00, 0x00, tc_min=1. With wrap=1 → 0x02, 0x00, 0xFE.
- Priority and break: in INC2, assert load=1, inc=1, dec=1 with d_in=0x40 → d_out=0x40, state LOAD. Then dec only → 0x3F, state DEC, not DEC2.
- (CNTR_OVF_FLAG_EN) wrap=1, load 0xFF, inc 1 cycle → d_out=0x00, ovf=1; ovf holds through idle; next load 0x05 → ovf=0.
